// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, default timing constants
// and a counter-width helper used by the TX scheduler and the bit timer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam int DEF_BIT_CNT        = 10417;   // 100 MHz / 9600 baud
  localparam int DEF_BITS_PER_FRAME = 10;      // start + 8 data + stop
  localparam int DEF_GAP_CNT        = 100000;

  typedef struct packed {
    logic       req;
    logic [7:0] data;
  } byte_req_t;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for one 8N1 frame: registered tick at the start of every
// bit period, current bit index, and a done strobe in the frame's last cycle.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_CNT        = DEF_BIT_CNT,
  parameter int BITS_PER_FRAME = DEF_BITS_PER_FRAME
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              enable,
  output logic                              tick,
  output logic [cnt_w(BITS_PER_FRAME)-1:0]  bit_idx,
  output logic                              done
);

  localparam int CW = cnt_w(BIT_CNT);
  localparam int IW = cnt_w(BITS_PER_FRAME);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BITS_PER_FRAME - 1);

  logic [CW-1:0] bit_cnt;
  logic          wrap;

  assign wrap = enable && (bit_cnt == CNT_LAST);
  assign done = wrap && (bit_idx == IDX_LAST);

  // tick is produced one cycle early so it lines up with bit_cnt == 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      tick    <= 1'b0;
    end else if (start) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      tick    <= 1'b1;
    end else if (wrap) begin
      bit_cnt <= '0;
      bit_idx <= done ? '0 : bit_idx + 1'b1;
      tick    <= !done;
    end else begin
      if (enable) bit_cnt <= bit_cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 serializer between two byte sources;
// owns the bit-rate timer and the inter-frame gap timer.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int BIT_CNT        = DEF_BIT_CNT,
  parameter int BITS_PER_FRAME = DEF_BITS_PER_FRAME,
  parameter int GAP_CNT        = DEF_GAP_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt1,
  output logic       tx_tick,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       owner
);

  localparam int IW = cnt_w(BITS_PER_FRAME);
  localparam int GW = cnt_w(GAP_CNT + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BITS_PER_FRAME - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CNT > 0) ? GW'(GAP_CNT - 1) : '0;

  tx_state_e     state_q, state_d;
  byte_req_t     rq [2];
  logic          any_req, win, last;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          gnt0_d, gnt1_d, busy_d, owner_d, last_d;
  logic [7:0]    tx_data_d;
  logic          tmr_start, tmr_en, tmr_done;
  logic [IW-1:0] bit_idx;

  assign rq[0] = '{req: req0, data: data0};
  assign rq[1] = '{req: req1, data: data1};

  assign any_req = rq[0].req || rq[1].req;
  // On a tie the requester that did not win last time goes next.
  assign win     = (rq[0].req && rq[1].req) ? !last : rq[1].req;

  assign tmr_start = (state_q == IDLE) && any_req;
  assign tmr_en    = (state_q == SEND);

  uart_bit_timer #(
    .BIT_CNT        (BIT_CNT),
    .BITS_PER_FRAME (BITS_PER_FRAME)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (tmr_start),
    .enable  (tmr_en),
    .tick    (tx_tick),
    .bit_idx (bit_idx),
    .done    (tmr_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      tx_data <= 8'h00;
      owner   <= 1'b0;
      last    <= 1'b1;
      gap_cnt <= '0;
    end else begin
      state_q <= state_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      busy    <= busy_d;
      tx_data <= tx_data_d;
      owner   <= owner_d;
      last    <= last_d;
      gap_cnt <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SEND;
      SEND:    if (tmr_done) state_d = (GAP_CNT == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    busy_d    = (state_d != IDLE);
    tx_data_d = tx_data;
    owner_d   = owner;
    last_d    = last;
    gap_d     = '0;
    if (tmr_start) begin
      gnt0_d    = !win;
      gnt1_d    = win;
      tx_data_d = rq[win].data;
      owner_d   = win;
      last_d    = win;
    end
    if ((state_q == GAP) && (state_d == GAP)) gap_d = gap_cnt + 1'b1;
  end

  a_idx_range: assert property (@(posedge clk) disable iff (!rst) bit_idx <= IDX_LAST);
  a_tick_busy: assert property (@(posedge clk) disable iff (!rst) tx_tick |-> busy);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a GAP_CNT=3 and a GAP_CNT=0 instance share stimulus;
// a frame-timing model predicts every output of both each cycle.
module tb_uart_tx_sched;

  localparam int BIT = 4;
  localparam int FRM = 10;
  localparam int NU  = 2;

  typedef struct packed {
    logic       gnt0;
    logic       gnt1;
    logic       tick;
    logic       busy;
    logic       owner;
    logic [7:0] txd;
  } obs_t;

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    int         ncyc;
    int         g0, g1, ticks, busy;
    logic [7:0] txd;
    logic       own;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, req0, req1;
  logic [7:0] data0, data1;
  logic gnt0_a, gnt1_a, tick_a, busy_a, own_a;
  logic gnt0_b, gnt1_b, tick_b, busy_b, own_b;
  logic [7:0] txd_a, txd_b;

  int total = 0, bad = 0, cyc = 0;
  int c_g0, c_g1, c_tick, c_busy;
  int fstart [NU], free_at [NU];
  logic [7:0] mtxd [NU];
  logic mown [NU], mlast [NU];
  vec_t tbl [7];

  uart_tx_sched #(.BIT_CNT(BIT), .BITS_PER_FRAME(FRM), .GAP_CNT(3)) dut (
    .clk(clk), .rst(rst_n), .req0(req0), .data0(data0), .gnt0(gnt0_a),
    .req1(req1), .data1(data1), .gnt1(gnt1_a), .tx_tick(tick_a),
    .tx_data(txd_a), .busy(busy_a), .owner(own_a));

  uart_tx_sched #(.BIT_CNT(BIT), .BITS_PER_FRAME(FRM), .GAP_CNT(0)) dut_z (
    .clk(clk), .rst(rst_n), .req0(req0), .data0(data0), .gnt0(gnt0_b),
    .req1(req1), .data1(data1), .gnt1(gnt1_b), .tx_tick(tick_b),
    .tx_data(txd_b), .busy(busy_b), .owner(own_b));

  always #5 clk = ~clk;

  function automatic int gap_of(input int u);
    return (u == 0) ? 3 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      fstart[u] = -100000; free_at[u] = 0;
      mtxd[u] = 8'h00; mown[u] = 1'b0; mlast[u] = 1'b1;
    end
  endtask

  // A frame starts the cycle after a sampled request once the previous
  // frame plus its gap has fully elapsed.
  task automatic model_edge();
    logic w;
    if (rst_n) begin
      for (int u = 0; u < NU; u++) begin
        if (cyc >= free_at[u] && (req0 || req1)) begin
          w = (req0 && req1) ? !mlast[u] : req1;
          fstart[u]  = cyc + 1;
          free_at[u] = cyc + 1 + FRM * BIT + gap_of(u);
          mtxd[u]    = w ? data1 : data0;
          mown[u]    = w;
          mlast[u]   = w;
        end
      end
    end
    cyc++;
  endtask

  function automatic obs_t exp_out(input int u);
    obs_t o;
    int d;
    o = '0;
    d = cyc - fstart[u];
    o.owner = mown[u];
    o.txd   = mtxd[u];
    if (d == 0) begin
      o.gnt0 = !mown[u];
      o.gnt1 = mown[u];
    end
    o.tick = (d >= 0) && (d < FRM * BIT) && (d % BIT == 0);
    o.busy = (d >= 0) && (d < FRM * BIT + gap_of(u));
    return o;
  endfunction

  function automatic obs_t act(input int u);
    obs_t o;
    if (u == 0) o = '{gnt0_a, gnt1_a, tick_a, busy_a, own_a, txd_a};
    else        o = '{gnt0_b, gnt1_b, tick_b, busy_b, own_b, txd_b};
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_gap3", 32'(act(0)), 32'(exp_out(0)));
    chk("model_gap0", 32'(act(1)), 32'(exp_out(1)));
    if (gnt0_a) c_g0++;
    if (gnt1_a) c_g1++;
    if (tick_a) c_tick++;
    if (busy_a) c_busy++;
  endtask

  task automatic tail(input int n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int g_cyc, zlow;
    bit found;
    int zg [$];

    tbl[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 89, 2, 1, 30, 129, 8'h11, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'hA5, 8'h00, 44, 1, 0, 10,  43, 8'hA5, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 8'h3C, 44, 0, 1, 10,  43, 8'h3C, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h5E,  1, 0, 1, 10,  43, 8'h5E, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 44, 1, 0, 10,  43, 8'h5A, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 10, 0, 0,  0,   0, 8'h5A, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h01, 8'hFE, 45, 1, 1, 20,  86, 8'h01, 1'b0};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    model_reset();
    repeat (3) step();
    chk("reset_state_gap3", 32'(act(0)), 32'h0);
    chk("reset_state_gap0", 32'(act(1)), 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      c_g0 = 0; c_g1 = 0; c_tick = 0; c_busy = 0;
      req0 = tbl[i].r0; req1 = tbl[i].r1; data0 = tbl[i].d0; data1 = tbl[i].d1;
      repeat (tbl[i].ncyc) step();
      tail(50);
      chk($sformatf("vec%0d_gnt0_count", i), c_g0, tbl[i].g0);
      chk($sformatf("vec%0d_gnt1_count", i), c_g1, tbl[i].g1);
      chk($sformatf("vec%0d_tick_count", i), c_tick, tbl[i].ticks);
      chk($sformatf("vec%0d_busy_cycles", i), c_busy, tbl[i].busy);
      chk($sformatf("vec%0d_tx_data", i), txd_a, tbl[i].txd);
      chk($sformatf("vec%0d_owner", i), own_a, tbl[i].own);
    end

    // Reset in SEND cycle 7 of a req1 frame, then a tie must go to req0.
    req1 = 1'b1; data1 = 8'h77;
    step();
    chk("mid_gnt1", gnt1_a, 1);
    req1 = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_now_gap3", 32'(act(0)), 32'h0);
    chk("mid_rst_now_gap0", 32'(act(1)), 32'h0);
    repeat (2) step();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; rst_n = 1'b1;
    step();
    chk("rst_rr_gnts", {gnt0_a, gnt1_a}, 2'b10);
    chk("rst_rr_txd", txd_a, 8'h11);
    tail(50);

    // Request raised mid-SEND is served at the first IDLE cycle + 1.
    req0 = 1'b1; data0 = 8'h44;
    step();
    chk("busy_req_gnt0", gnt0_a, 1);
    g_cyc = cyc;
    req0 = 1'b0;
    repeat (5) step();
    req1 = 1'b1; data1 = 8'h99;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (gnt1_a) begin
        found = 1'b1;
        chk("busy_req_delay", cyc - g_cyc, 44);
        chk("busy_req_txd", txd_a, 8'h99);
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL busy_req_timeout: got no gnt1 expected gnt1 within 100 cycles");
    end
    tail(50);

    // req1 pulsed only during GAP: never granted, round-robin history intact.
    req0 = 1'b1; data0 = 8'h0F;
    step();
    chk("wd_gnt0", gnt0_a, 1);
    req0 = 1'b0;
    repeat (40) step();
    c_g1 = 0;
    req1 = 1'b1; data1 = 8'hEE;
    repeat (2) step();
    req1 = 1'b0;
    repeat (20) step();
    chk("wd_no_gnt1", c_g1, 0);
    chk("wd_owner", own_a, 0);
    chk("wd_idle", busy_a, 0);
    chk("wd_txd", txd_a, 8'h0F);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h12; data1 = 8'h34;
    step();
    chk("wd_last_kept", {gnt0_a, gnt1_a}, 2'b01);
    tail(50);

    // Zero-gap build with req0 held: 41-cycle grant period, 1 idle cycle.
    req0 = 1'b1; data0 = 8'hC5;
    zlow = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      if (gnt0_b) zg.push_back(cyc);
      if (zg.size() > 0 && !busy_b) zlow++;
    end
    chk("zero_gap_grants", zg.size(), 4);
    for (int i = 1; i < zg.size(); i++)
      chk($sformatf("zero_gap_period%0d", i), zg[i] - zg[i-1], 41);
    chk("zero_gap_busy_low", zlow, 3);
    tail(50);

    // Random requesters that mostly hold until granted, sometimes withdraw.
    for (int i = 0; i < 400; i++) begin
      step();
      if (req0) begin
        if (gnt0_a || $urandom_range(0, 49) == 0) req0 = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        req0 = 1'b1; data0 = 8'($urandom);
      end
      if (req1) begin
        if (gnt1_a || $urandom_range(0, 49) == 0) req1 = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        req1 = 1'b1; data1 = 8'($urandom);
      end
    end
    tail(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
